// File: rtl/gate_sweep_ctrl_if.sv
// Signal bundle between the gate-sweep controller and its environment (gate unit + host).
// master = controller side, slave = gate unit / host side.
interface gate_sweep_ctrl_if;
  logic        start;
  logic        y_in;
  logic        a;
  logic        b;
  logic [2:0]  sel;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] truth;
  logic [5:0]  mismatch_cnt;

  modport master (
    input  start, y_in,
    output a, b, sel, busy, done, pass, truth, mismatch_cnt
  );

  modport slave (
    output start, y_in,
    input  a, b, sel, busy, done, pass, truth, mismatch_cnt
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Self-test sweeper for the 8-op gate unit: drives all 32 {sel,a,b} vectors, samples y
// after a settle window, builds the truth table and counts mismatches against a golden model.
//
// state   | meaning
// IDLE    | waiting for start; results from the last sweep held
// WAIT    | vector driven, settle down-counter running
// CAPTURE | sample y_in into truth[idx], compare with golden
// FINISH  | one-cycle done pulse, pass valid
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input logic               clk,
  input logic               rst,
  gate_sweep_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE,
    FINISH
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_t      state;
  logic [4:0]  idx;
  logic [3:0]  cnt;
  logic        a_q;
  logic        b_q;
  logic [2:0]  sel_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [31:0] truth_q;
  logic [5:0]  mismatch_q;
  logic        miss;

  function automatic logic golden(input logic [4:0] v);
    logic ga;
    logic gb;
    ga = v[1];
    gb = v[0];
    case (v[4:2])
      3'd0:    golden = ga & gb;
      3'd1:    golden = ga | gb;
      3'd2:    golden = ~ga;
      3'd3:    golden = ~(ga & gb);
      3'd4:    golden = ~(ga | gb);
      3'd5:    golden = ga ^ gb;
      3'd6:    golden = ~(ga ^ gb);
      default: golden = 1'b0;
    endcase
  endfunction

  assign miss = (bus.y_in != golden(idx));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      truth_q    <= '0;
      mismatch_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx                <= '0;
            {sel_q, a_q, b_q}  <= '0;
            truth_q            <= '0;
            mismatch_q         <= '0;
            pass_q             <= 1'b0;
            cnt                <= CNT_INIT;
            busy_q             <= 1'b1;
            state              <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             state <= CAPTURE;
        end
        CAPTURE: begin
          truth_q[idx] <= bus.y_in;
          if (miss) mismatch_q <= mismatch_q + 6'd1;
          if (idx == 5'd31) begin
            // pass uses the count including this last vector, so it is valid with done
            pass_q <= (mismatch_q == 6'd0) && !miss;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= FINISH;
          end else begin
            idx               <= idx + 5'd1;
            {sel_q, a_q, b_q} <= idx + 5'd1;
            cnt               <= CNT_INIT;
            state             <= WAIT;
          end
        end
        FINISH: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a            = a_q;
  assign bus.b            = b_q;
  assign bus.sel          = sel_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pass         = pass_q;
  assign bus.truth        = truth_q;
  assign bus.mismatch_cnt = mismatch_q;

endmodule
